// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and baud encodings, tick-period helpers,
// and the transmit FSM state codes.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] BD_1200 = 2'b00;
  localparam logic [1:0] BD_2400 = 2'b01;
  localparam logic [1:0] BD_4800 = 2'b10;
  localparam logic [1:0] BD_9600 = 2'b11;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Frame configuration, captured once per frame when a word is popped.
  typedef struct packed {
    logic       d_num;
    logic       s_num;
    logic [1:0] par;
    logic [1:0] bd_rate;
  } frame_cfg_t;

  function automatic int unsigned baud_rate(input logic [1:0] sel);
    case (sel)
      BD_1200: return 1200;
      BD_2400: return 2400;
      BD_4800: return 4800;
      default: return 9600;
    endcase
  endfunction

  // Clocks per oversample tick, rounded up.
  function automatic int unsigned max_ticks(input int unsigned clk_freq,
                                            input int unsigned baud);
    return (clk_freq + baud * OVERSAMPLE - 1) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port; pointers carry an extra wrap
// bit so full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int unsigned DBITS = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [DBITS-1:0] i_wr_data,
  input  logic             i_rd,
  output logic [DBITS-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DBITS-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [DBITS-1:0] rd_data_reg;
  logic             wr_ok;
  logic             rd_ok;

  assign o_empty = (wr_ptr_reg == rd_ptr_reg);
  assign o_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  // Full is sampled before any same-cycle pop, so a write while full is dropped.
  assign wr_ok = i_wr && !o_full;
  assign rd_ok = i_rd && !o_empty;

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr_reg[AW-1:0]] <= i_wr_data;
    if (rd_ok) rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign o_rd_data = rd_data_reg;

endmodule

// File: rtl/tx_top.sv
// UART transmitter: FIFO-buffered bytes serialised LSB-first with optional
// parity and 1/2 stop bits, timed by a 16x oversampled baud tick.
module tx_top
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned DBITS    = 8,
  parameter int unsigned SBITS    = 2,
  parameter int unsigned DEPTH    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [DBITS-1:0] i_wr_data,
  input  logic             i_d_num,
  input  logic             i_s_num,
  input  logic [1:0]       i_par,
  input  logic [1:0]       i_bd_rate,
  output logic             o_tx,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_busy
);

  localparam int unsigned TICK_W = $clog2(max_ticks(CLK_FREQ, baud_rate(BD_1200)) + 1);
  localparam int unsigned IDX_W  = $clog2(DBITS);
  localparam logic [3:0]  OS_LAST = 4'(OVERSAMPLE - 1);

  logic [2:0]        state_reg;
  logic              tx_reg;
  logic [TICK_W-1:0] tick_cnt_reg;
  logic [3:0]        os_cnt_reg;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic              stop_idx_reg;
  logic              load_reg;
  logic [DBITS-1:0]  data_reg;
  logic              par_bit_reg;
  frame_cfg_t        cfg_reg;

  logic [DBITS-1:0]  fifo_rd_data;
  logic              fifo_rd;
  logic [DBITS-1:0]  frame_data;
  logic [TICK_W-1:0] tick_lim_tab [4];
  logic [TICK_W-1:0] tick_lim;
  logic [IDX_W-1:0]  last_idx;
  logic              bit_done;
  logic              par_en;
  logic              stop_more;

  assign fifo_rd = (state_reg == ST_IDLE) && !o_empty;

  sync_fifo #(.DBITS(DBITS), .DEPTH(DEPTH)) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr      (i_wr),
    .i_wr_data (i_wr_data),
    .i_rd      (fifo_rd),
    .o_rd_data (fifo_rd_data),
    .o_full    (o_full),
    .o_empty   (o_empty)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_tick_lim
    assign tick_lim_tab[gi] = TICK_W'(max_ticks(CLK_FREQ, baud_rate(2'(gi))) - 1);
  end

  assign tick_lim  = tick_lim_tab[cfg_reg.bd_rate];
  assign bit_done  = (tick_cnt_reg == tick_lim) && (os_cnt_reg == OS_LAST);
  assign last_idx  = cfg_reg.d_num ? IDX_W'(DBITS - 1) : IDX_W'(DBITS - 2);
  assign par_en    = (cfg_reg.par == PAR_EVEN) || (cfg_reg.par == PAR_ODD);
  assign stop_more = cfg_reg.s_num && (SBITS > 1) && !stop_idx_reg;

  // In 7-bit frames the top bit takes no part in data or parity.
  always_comb begin
    frame_data = fifo_rd_data;
    if (!cfg_reg.d_num) frame_data[DBITS-1] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      tx_reg       <= 1'b1;
      tick_cnt_reg <= '0;
      os_cnt_reg   <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      load_reg     <= 1'b0;
      data_reg     <= '0;
      par_bit_reg  <= 1'b0;
      cfg_reg      <= '0;
    end else begin
      load_reg <= 1'b0;
      if (state_reg != ST_IDLE) begin
        if (tick_cnt_reg == tick_lim) begin
          tick_cnt_reg <= '0;
          os_cnt_reg   <= (os_cnt_reg == OS_LAST) ? 4'd0 : os_cnt_reg + 1'b1;
        end else begin
          tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
      end
      // The FIFO read port is registered, so the word lands one clock into START.
      if (load_reg) begin
        data_reg    <= frame_data;
        par_bit_reg <= (^frame_data) ^ (cfg_reg.par == PAR_ODD);
      end
      case (state_reg)
        ST_IDLE: begin
          if (!o_empty) begin
            state_reg    <= ST_START;
            tx_reg       <= 1'b0;
            tick_cnt_reg <= '0;
            os_cnt_reg   <= '0;
            load_reg     <= 1'b1;
            cfg_reg      <= '{d_num: i_d_num, s_num: i_s_num, par: i_par, bd_rate: i_bd_rate};
          end
        end
        ST_START: begin
          if (bit_done) begin
            state_reg   <= ST_DATA;
            tx_reg      <= data_reg[0];
            data_reg    <= data_reg >> 1;
            bit_idx_reg <= '0;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_idx_reg == last_idx) begin
              state_reg    <= par_en ? ST_PARITY : ST_STOP;
              tx_reg       <= par_en ? par_bit_reg : 1'b1;
              stop_idx_reg <= 1'b0;
            end else begin
              tx_reg      <= data_reg[0];
              data_reg    <= data_reg >> 1;
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            state_reg    <= ST_STOP;
            tx_reg       <= 1'b1;
            stop_idx_reg <= 1'b0;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (stop_more) stop_idx_reg <= 1'b1;
            else           state_reg    <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          tx_reg    <= 1'b1;
        end
      endcase
    end
  end

  assign o_tx   = tx_reg;
  assign o_busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_tx_top.sv
// Directed bench for tx_top using a reduced clock frequency so whole frames
// fit in a short run; bit periods are hand-computed for CLK_FREQ = 160 kHz.
module tb_tx_top;

  localparam int unsigned CLK_FREQ = 160_000;
  localparam int unsigned DBITS    = 8;
  localparam int unsigned SBITS    = 2;
  localparam int unsigned DEPTH    = 8;
  // ceil(160000/(baud*16)) * 16 for 1200/2400/4800/9600: 9,5,3,2 ticks
  localparam int BIT_CLK [4] = '{144, 80, 48, 32};

  logic       clk = 1'b0;
  logic       rst;
  logic       wr;
  logic [7:0] wr_data;
  logic       d_num;
  logic       s_num;
  logic [1:0] par;
  logic [1:0] bd;
  logic       tx;
  logic       full;
  logic       empty;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        d_num;
    logic        s_num;
    logic [1:0]  par;
    logic [1:0]  bd;
    logic [15:0] exp_bits;  // bit 0 is the start bit, in line order
    int          nbits;
  } vec_t;

  vec_t vecs [6];

  tx_top #(.CLK_FREQ(CLK_FREQ), .DBITS(DBITS), .SBITS(SBITS), .DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr      (wr),
    .i_wr_data (wr_data),
    .i_d_num   (d_num),
    .i_s_num   (s_num),
    .i_par     (par),
    .i_bd_rate (bd),
    .o_tx      (tx),
    .o_full    (full),
    .o_empty   (empty),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Follows one frame on the line, one clock per negedge. pre > 0 means the
  // start bit is already that many clocks old when the task is called.
  task automatic check_frame(input logic [15:0] bits, input int nbits, input int bc,
                             input int pre, input bit scramble, input string name,
                             output int waited);
    int w;
    int bad;
    int first;
    logic busy_last;
    w = 0;
    waited = 0;
    busy_last = 1'b0;
    if (pre == 0) begin
      do begin
        @(negedge clk);
        w++;
      end while (tx !== 1'b0 && w < 3000);
      waited = w;
      if (tx !== 1'b0) begin
        chk({name, " start_seen"}, 32'(tx), 32'd0);
        return;
      end
    end
    if (scramble) begin
      d_num = ~d_num;
      s_num = ~s_num;
      par   = ~par;
      bd    = ~bd;
    end
    chk({name, " busy_in_start"}, 32'(busy), 32'd1);
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      first = (b == 0) ? ((pre == 0) ? 1 : pre) : 0;
      for (int c = first; c < bc; c++) begin
        @(negedge clk);
        if (tx !== bits[b]) bad++;
      end
      busy_last = busy;
      chk($sformatf("%s bit%0d_bad_clocks", name, b), 32'(bad), 32'd0);
    end
    chk({name, " busy_last_stop"}, 32'(busy_last), 32'd1);
    @(negedge clk);
    chk({name, " idle_tx"}, 32'(tx), 32'd1);
    chk({name, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int w;
    int seen;
    logic [7:0] d;

    rst = 1'b1; wr = 1'b0; wr_data = '0;
    d_num = 1'b1; s_num = 1'b0; par = 2'b00; bd = 2'b00;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, 2'b00, 2'b00, 16'b000000_1_10100101_0, 10};   // 8N1 1200
    vecs[1] = '{8'h35, 1'b0, 1'b0, 2'b01, 2'b00, 16'b000000_1_0_0110101_0, 10};  // 7E1 1200
    vecs[2] = '{8'h35, 1'b1, 1'b1, 2'b10, 2'b11, 16'b0000_11_1_00110101_0, 12};  // 8O2 9600
    vecs[3] = '{8'h80, 1'b0, 1'b0, 2'b10, 2'b10, 16'b000000_1_1_0000000_0, 10};  // 7O1 4800
    vecs[4] = '{8'h01, 1'b1, 1'b1, 2'b01, 2'b10, 16'b0000_11_1_00000001_0, 12};  // 8E2 4800
    vecs[5] = '{8'h3C, 1'b1, 1'b0, 2'b11, 2'b01, 16'b000000_1_00111100_0, 10};   // par 11 = none

    repeat (3) @(negedge clk);
    chk("reset tx", 32'(tx), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset empty", 32'(empty), 32'd1);
    chk("reset full", 32'(full), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single frames; config inputs are inverted once the frame has started.
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; wr_data = vecs[i].data;
      d_num = vecs[i].d_num; s_num = vecs[i].s_num; par = vecs[i].par; bd = vecs[i].bd;
      @(negedge clk);
      wr = 1'b0;
      chk($sformatf("vec%0d empty_after_write", i), 32'(empty), 32'd0);
      chk($sformatf("vec%0d tx_before_start", i), 32'(tx), 32'd1);
      check_frame(vecs[i].exp_bits, vecs[i].nbits, BIT_CLK[vecs[i].bd], 0, 1'b1,
                  $sformatf("vec%0d", i), w);
      chk($sformatf("vec%0d start_latency", i), 32'(w), 32'd1);
      chk($sformatf("vec%0d empty_after_frame", i), 32'(empty), 32'd1);
      $display("vec %0d: data=%02h d_num=%0b s_num=%0b par=%02b bd=%02b bits=%0d",
               i, vecs[i].data, vecs[i].d_num, vecs[i].s_num, vecs[i].par, vecs[i].bd,
               vecs[i].nbits);
    end

    // DEPTH+1 back-to-back writes, then one more that must be dropped.
    d_num = 1'b1; s_num = 1'b0; par = 2'b00; bd = 2'b11;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("burst full_before_last", 32'(full), 32'd0);
      if (i == 9) begin
        chk("burst full", 32'(full), 32'd1);
        wr_data = 8'hEE;
      end else begin
        wr_data = 8'h10 + 8'(i);
      end
      wr = 1'b1;
      @(negedge clk);
    end
    wr = 1'b0;
    chk("burst full_after_drop", 32'(full), 32'd1);
    for (int f = 0; f < 9; f++) begin
      d = 8'h10 + 8'(f);
      check_frame(16'({1'b1, d, 1'b0}), 10, BIT_CLK[3], (f == 0) ? 9 : 0, 1'b0,
                  $sformatf("burst%0d", f), w);
      if (f > 0) chk($sformatf("burst%0d idle_gap", f), 32'(w), 32'd1);
      $display("burst frame %0d: data=%02h", f, d);
    end
    chk("burst empty_end", 32'(empty), 32'd1);
    chk("burst full_end", 32'(full), 32'd0);
    seen = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) seen++;
    end
    chk("burst dropped_word_not_sent", 32'(seen), 32'd0);

    // Reset in the middle of the data bits with three words still queued.
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; wr_data = 8'h55 + 8'(i);
      @(negedge clk);
    end
    wr = 1'b0;
    repeat (96) @(negedge clk);
    chk("midrst busy_before", 32'(busy), 32'd1);
    chk("midrst empty_before", 32'(empty), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst tx", 32'(tx), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst empty", 32'(empty), 32'd1);
    chk("midrst full", 32'(full), 32'd0);
    rst = 1'b0;
    seen = 0;
    repeat (32 * 12) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) seen++;
    end
    chk("midrst no_frames_after", 32'(seen), 32'd0);
    $display("mid-frame reset: 4 words written, line idle after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
